// File: rtl/fifo_seq_pkg.sv
// Shared types and counter-width helpers for the FIFO bank sequencer.
package fifo_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      SETTLE = 3'd2,
      DRAIN  = 3'd3,
      FLUSH  = 3'd4
   } state_t;

   localparam int DEF_NUM_FIFOS  = 8;
   localparam int DEF_DEPTH      = 8;
   localparam int DEF_DATA_WIDTH = 8;

   // A counter over 0..limit-1 needs at least one bit even when limit is 1.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

   localparam int DEF_WORD_CNT_W = cnt_width(DEF_DEPTH);
   localparam int DEF_FIFO_IDX_W = cnt_width(DEF_NUM_FIFOS);

endpackage

// File: rtl/wrap_counter.sv
// Counter over 0..LIMIT-1 with an explicit compare-to-limit wrap strobe.
module wrap_counter
   import fifo_seq_pkg::*;
#(
   parameter int LIMIT = 8,
   localparam int W = cnt_width(LIMIT)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         wrap
);

   assign wrap = inc && (count == W'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/fifo_bank_sequencer.sv
// Fills a bank of FIFOs in FIFO-major order, then drains them column by column.
module fifo_bank_sequencer
   import fifo_seq_pkg::*;
#(
   parameter int NUM_FIFOS  = DEF_NUM_FIFOS,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_ready,
   output logic [NUM_FIFOS-1:0]  fifo_wren,
   output logic [DATA_WIDTH-1:0] fifo_wdata,
   output logic [NUM_FIFOS-1:0]  fifo_rden,
   input  logic [NUM_FIFOS-1:0]  fifo_full,
   input  logic [NUM_FIFOS-1:0]  fifo_empty,
   input  logic                  sink_ready,
   output logic                  drain_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int WORD_W = cnt_width(DEPTH);
   localparam int IDX_W  = cnt_width(NUM_FIFOS);

   state_t            state;
   state_t            next_state;
   logic              hs;
   logic              rd_issue;
   logic              cnt_clr;
   logic              word_wrap;
   logic              fifo_wrap;
   logic              rd_wrap;
   logic [WORD_W-1:0] word_cnt;
   logic [IDX_W-1:0]  fifo_idx;
   logic [WORD_W-1:0] rd_cnt;
   logic              wr_err;
   logic              rd_err;
   logic              unused_cnt_bits;

   assign src_ready = (state == FILL);
   assign hs        = src_valid && src_ready;
   assign rd_issue  = (state == DRAIN) && sink_ready;
   assign cnt_clr   = (state == IDLE);
   assign wr_err    = |(fifo_wren & fifo_full);
   assign rd_err    = (|fifo_rden) && (|fifo_empty);

   // Word and read positions only matter through their wrap strobes.
   assign unused_cnt_bits = ^{word_cnt, rd_cnt};

   wrap_counter #(.LIMIT(DEPTH)) u_word_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (hs),
      .count (word_cnt),
      .wrap  (word_wrap)
   );

   wrap_counter #(.LIMIT(NUM_FIFOS)) u_fifo_idx (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (word_wrap),
      .count (fifo_idx),
      .wrap  (fifo_wrap)
   );

   wrap_counter #(.LIMIT(DEPTH)) u_rd_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (rd_issue),
      .count (rd_cnt),
      .wrap  (rd_wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = start ? FILL : IDLE;
         FILL:    next_state = fifo_wrap ? SETTLE : FILL;
         SETTLE:  next_state = DRAIN;
         DRAIN:   next_state = rd_wrap ? FLUSH : DRAIN;
         FLUSH:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // busy stays high through the done cycle so it drops one cycle after done.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_wren   <= '0;
         fifo_wdata  <= '0;
         fifo_rden   <= '0;
         drain_valid <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else begin
         fifo_wren   <= hs ? ({{(NUM_FIFOS-1){1'b0}}, 1'b1} << fifo_idx) : '0;
         if (hs) begin
            fifo_wdata <= src_data;
         end
         fifo_rden   <= rd_issue ? '1 : '0;
         drain_valid <= fifo_rden[0];
         done        <= (state == FLUSH);
         busy        <= (next_state != IDLE) || (state == FLUSH);
         if ((state == IDLE) && start) begin
            err <= 1'b0;
         end else if (wr_err || rd_err) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_bank_sequencer.sv
// Directed bench for fifo_bank_sequencer with a behavioural FIFO bank attached.
module tb_fifo_bank_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        src_valid;
   logic [7:0]  src_data;
   logic        src_ready;
   logic [7:0]  fifo_wren;
   logic [7:0]  fifo_wdata;
   logic [7:0]  fifo_rden;
   logic [7:0]  fifo_full;
   logic [7:0]  fifo_empty;
   logic        sink_ready;
   logic        drain_valid;
   logic        busy;
   logic        done;
   logic        err;

   int n_assert;
   int n_fail;
   int rel;
   int words;
   int wr_cnt;
   int dv_cnt;
   int rd_pulses;
   int first_rd;
   int last_rd;
   int done_cnt;
   int done_cyc;
   int overlap;
   bit force_full2;
   bit hs;

   logic [7:0] mem [8][8];
   int         fcount [8];
   int         wp [8];
   int         rp [8];
   logic [7:0] odata [8];

   fifo_bank_sequencer #(.NUM_FIFOS(8), .DEPTH(8), .DATA_WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_ready   (src_ready),
      .fifo_wren   (fifo_wren),
      .fifo_wdata  (fifo_wdata),
      .fifo_rden   (fifo_rden),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .sink_ready  (sink_ready),
      .drain_valid (drain_valid),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO bank: read has priority over write, registered read data.
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (rst) begin
            fcount[i] <= 0;
            wp[i]     <= 0;
            rp[i]     <= 0;
            odata[i]  <= 8'h00;
         end else if (fifo_rden[i]) begin
            if (fcount[i] > 0) begin
               odata[i]  <= mem[i][rp[i]];
               rp[i]     <= (rp[i] + 1) % 8;
               fcount[i] <= fcount[i] - 1;
            end
         end else if (fifo_wren[i]) begin
            if (fcount[i] < 8) begin
               mem[i][wp[i]] <= fifo_wdata;
               wp[i]         <= (wp[i] + 1) % 8;
               fcount[i]     <= fcount[i] + 1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         fifo_full[i]  = (fcount[i] == 8) || (force_full2 && (i == 2));
         fifo_empty[i] = (fcount[i] == 0);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [63:0] col_obs;
      logic [63:0] col_exp;
      @(posedge clk);
      #1;
      rel++;
      if (|fifo_wren) begin
         chk("wren_onehot", 64'(fifo_wren), 64'(1) << (wr_cnt / 8));
         chk("wdata", 64'(fifo_wdata), 64'(wr_cnt % 256));
         wr_cnt++;
      end
      if ((|fifo_wren) && (|fifo_rden)) overlap++;
      if (|fifo_rden) begin
         rd_pulses++;
         if (first_rd < 0) first_rd = rel;
         last_rd = rel;
      end
      if (drain_valid) begin
         for (int i = 0; i < 8; i++) begin
            col_obs[i*8 +: 8] = odata[i];
            col_exp[i*8 +: 8] = 8'(i * 8 + dv_cnt);
         end
         chk("drain_column", col_obs, col_exp);
         dv_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = rel;
      end
   endtask

   task automatic clear_stats();
      rel       = 0;
      words     = 0;
      wr_cnt    = 0;
      dv_cnt    = 0;
      rd_pulses = 0;
      first_rd  = -1;
      last_rd   = -1;
      done_cnt  = 0;
      done_cyc  = -1;
      overlap   = 0;
   endtask

   // vmode 0: src_valid held high; vmode 1: src_valid on even cycles only.
   task automatic run(input int vmode, input int stall_at, input int stall_len,
                      input bit force_err, input bit start_pulses,
                      input int exp_done, input bit exp_err);
      clear_stats();
      start      = 1'b1;
      src_valid  = 1'b0;
      sink_ready = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'(1));
      chk("src_ready_after_start", 64'(src_ready), 64'(1));
      chk("err_cleared_by_start", 64'(err), 64'(0));
      while (done_cnt == 0 && rel < 400) begin
         src_valid   = (vmode == 0) ? 1'b1 : ((rel % 2) == 0);
         src_data    = 8'(words);
         sink_ready  = !((rel >= stall_at) && (rel < stall_at + stall_len));
         start       = start_pulses && ((rel == 10) || (rel == 70));
         force_full2 = force_err && (rel >= 17) && (rel <= 25);
         hs          = src_valid && src_ready;
         step();
         if (hs) words++;
      end
      start       = 1'b0;
      src_valid   = 1'b0;
      sink_ready  = 1'b1;
      force_full2 = 1'b0;
      chk("done_seen", 64'(done_cnt), 64'(1));
      chk("done_cycle", 64'(done_cyc), 64'(exp_done));
      chk("busy_at_done", 64'(busy), 64'(1));
      chk("err_at_done", 64'(err), 64'(exp_err));
      chk("writes_total", 64'(wr_cnt), 64'(64));
      chk("drain_valid_pulses", 64'(dv_cnt), 64'(8));
      chk("rden_pulses", 64'(rd_pulses), 64'(8));
      chk("rden_bubbles", 64'(last_rd - first_rd + 1 - 8), 64'(stall_len));
      chk("wren_rden_overlap", 64'(overlap), 64'(0));
      step();
      chk("busy_after_done", 64'(busy), 64'(0));
      chk("done_single_pulse", 64'(done), 64'(0));
      chk("err_sticky_after_done", 64'(err), 64'(exp_err));
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      start       = 1'b0;
      src_valid   = 1'b0;
      src_data    = 8'h00;
      sink_ready  = 1'b1;
      force_full2 = 1'b0;
      clear_stats();
      step();
      step();
      rst = 1'b0;
      chk("reset_outputs",
          64'({src_ready, busy, done, err, drain_valid, fifo_wren, fifo_rden, fifo_wdata}),
          64'(0));

      // Abort mid-fill after five words.
      clear_stats();
      start = 1'b1;
      step();
      start     = 1'b0;
      src_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         src_data = 8'(k);
         step();
      end
      src_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_fill_outputs",
          64'({src_ready, busy, done, err, drain_valid, fifo_wren, fifo_rden, fifo_wdata}),
          64'(0));
      chk("rst_mid_fill_writes_seen", 64'(wr_cnt), 64'(5));
      step();
      step();
      step();
      chk("rst_no_done", 64'(done_cnt), 64'(0));
      chk("rst_idle", 64'({busy, src_ready}), 64'(0));

      run(0, 1000, 0, 1'b0, 1'b0, 75, 1'b0);
      run(1, 1000, 0, 1'b0, 1'b0, 139, 1'b0);
      run(0, 68, 3, 1'b0, 1'b0, 78, 1'b0);
      run(0, 1000, 0, 1'b1, 1'b0, 75, 1'b1);
      run(0, 1000, 0, 1'b0, 1'b1, 75, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
